grey_mode_ctrl: RTL and testbench

GREY_MODE_CTRL -- requirements
Module: grey_mode_ctrl

---
 rtl/grey_mode_ctrl.sv | 164 ++++++++++++++++
 tb/tb_grey_mode_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/grey_mode_ctrl.sv
// Grey/binary mode controller: debounced switches commit on frame start (1-cycle latency after rise).
// Optional ADAPTIVE_THRESH_EN: per-frame mean of the first 65536 pixels becomes the binary threshold.
module grey_mode_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYC   = 16'd50000,
  parameter logic [11:0] DEFAULT_THRESH = 12'd2000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iGRAY_SW,
  input  logic        iBINARY_SW,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [11:0] iGREY,
  output logic        oGRAY_MODE,
  output logic        oBINARY_MODE,
  output logic [11:0] oTHRESHOLD,
  output logic        oMODE_CHG
);

  // Index 0 = grey switch, index 1 = binary switch.
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_db;
  logic [15:0] r_db_cnt [2];
  logic        r_fval_d;
  logic        r_gray_mode;
  logic        r_bin_mode;
  logic        r_mode_chg;

  logic        w_rise;
  logic        w_fall;
  logic        w_gray_new;
  logic        w_bin_new;
  logic [15:0] w_db_last;

  assign w_db_last  = DEBOUNCE_CYC - 16'd1;
  assign w_rise     = iFVAL & ~r_fval_d;
  assign w_fall     = ~iFVAL & r_fval_d;
  assign w_gray_new = r_db[0];
  assign w_bin_new  = r_db[1] & r_db[0];

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= {iBINARY_SW, iGRAY_SW};
      r_sync2 <= r_sync1;
    end
  end

  // A switch must disagree with its debounced value for DEBOUNCE_CYC straight cycles.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_db <= 2'b00;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= 16'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_db[k]) begin
          if (r_db_cnt[k] == w_db_last) begin
            r_db[k]     <= r_sync2[k];
            r_db_cnt[k] <= 16'd0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + 16'd1;
          end
        end else begin
          r_db_cnt[k] <= 16'd0;
        end
      end
    end
  end

  // Reset to 1 so a frame already running at reset release is not seen as a start.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_fval_d <= 1'b1;
    else         r_fval_d <= iFVAL;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_gray_mode <= 1'b0;
      r_bin_mode  <= 1'b0;
      r_mode_chg  <= 1'b0;
    end else if (w_rise) begin
      r_gray_mode <= w_gray_new;
      r_bin_mode  <= w_bin_new;
      r_mode_chg  <= (w_gray_new != r_gray_mode) | (w_bin_new != r_bin_mode);
    end else begin
      r_mode_chg  <= 1'b0;
    end
  end

  assign oGRAY_MODE   = r_gray_mode;
  assign oBINARY_MODE = r_bin_mode;
  assign oMODE_CHG    = r_mode_chg;

`ifdef ADAPTIVE_THRESH_EN
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD, S_UPDATE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [27:0] r_sum;
  logic [16:0] r_count;
  logic [11:0] r_thresh;
  logic        w_pix;
  logic        w_clr;
  logic        w_acc;
  logic        w_load;

  assign w_pix = iFVAL & iDVAL;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_rise) w_state_nxt = S_ACCUM;
      S_ACCUM: begin
        if (w_fall)                                w_state_nxt = S_IDLE;
        else if (w_pix && r_count == 17'd65535)    w_state_nxt = S_HOLD;
      end
      S_HOLD:   if (w_fall) w_state_nxt = S_UPDATE;
      // A new frame may start right in the update cycle.
      S_UPDATE: w_state_nxt = w_rise ? S_ACCUM : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_clr  = (w_state_nxt == S_ACCUM) && (r_state != S_ACCUM);
    w_acc  = (r_state == S_ACCUM) && w_pix;
    w_load = (r_state == S_UPDATE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sum   <= 28'd0;
      r_count <= 17'd0;
    end else if (w_clr) begin
      r_sum   <= 28'd0;
      r_count <= 17'd0;
    end else if (w_acc) begin
      r_sum   <= r_sum + {16'd0, iGREY};
      r_count <= r_count + 17'd1;
    end
  end

  // Sum of exactly 65536 pixels: the top 12 bits are the frame mean.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)     r_thresh <= DEFAULT_THRESH;
    else if (w_load) r_thresh <= r_sum[27:16];
  end

  assign oTHRESHOLD = r_thresh;
`else
  logic w_unused_pix;
  assign w_unused_pix = ^{iDVAL, iGREY};
  assign oTHRESHOLD   = DEFAULT_THRESH;
`endif

endmodule

// File: tb/tb_grey_mode_ctrl.sv
// Directed bench for grey_mode_ctrl: scoreboard of expected outputs, checked by immediate assertions.
module tb_grey_mode_ctrl;
  localparam logic [15:0] DB    = 16'd16;
  localparam logic [11:0] DEF_T = 12'd2000;
  localparam int          DBI   = 16;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iGRAY_SW = 1'b0;
  logic        iBINARY_SW = 1'b0;
  logic        iFVAL = 1'b0;
  logic        iDVAL = 1'b0;
  logic [11:0] iGREY = 12'd0;
  logic        oGRAY_MODE;
  logic        oBINARY_MODE;
  logic [11:0] oTHRESHOLD;
  logic        oMODE_CHG;

  grey_mode_ctrl #(.DEBOUNCE_CYC(DB), .DEFAULT_THRESH(DEF_T)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iGRAY_SW    (iGRAY_SW),
    .iBINARY_SW  (iBINARY_SW),
    .iFVAL       (iFVAL),
    .iDVAL       (iDVAL),
    .iGREY       (iGREY),
    .oGRAY_MODE  (oGRAY_MODE),
    .oBINARY_MODE(oBINARY_MODE),
    .oTHRESHOLD  (oTHRESHOLD),
    .oMODE_CHG   (oMODE_CHG)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    string       tag;
    logic        gray;
    logic        bin;
    logic [11:0] thr;
    logic        chg;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   chg_cnt = 0;
  int   snap;

  always @(posedge iCLK) if (oMODE_CHG === 1'b1) chg_cnt <= chg_cnt + 1;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic g, input logic b,
                      input logic [11:0] thr, input logic chg);
    sb.push_back('{tag, g, b, thr, chg});
  endtask

  task automatic pop_check;
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_underflow observed=0 entries expected>=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, "_gray"}, {31'd0, oGRAY_MODE},   {31'd0, e.gray});
    cmp({e.tag, "_bin"},  {31'd0, oBINARY_MODE}, {31'd0, e.bin});
    cmp({e.tag, "_thr"},  {20'd0, oTHRESHOLD},   {20'd0, e.thr});
    cmp({e.tag, "_chg"},  {31'd0, oMODE_CHG},    {31'd0, e.chg});
  endtask

  initial begin
    tick(3);
    push("rst", 1'b0, 1'b0, DEF_T, 1'b0); pop_check;
    iRST_N = 1'b1;
    tick(2);

    // Test 1: grey pulse one cycle short of the debounce window is rejected.
    snap = chg_cnt;
    iGRAY_SW = 1'b1; tick(DBI - 1);
    iGRAY_SW = 1'b0; tick(3 * DBI);
    iFVAL = 1'b1;
    push("t1_commit", 1'b0, 1'b0, DEF_T, 1'b0); tick; pop_check;
    tick(2); iFVAL = 1'b0; tick(2);
    cmp("t1_chg_cnt", chg_cnt - snap, 0);

    // Test 2: both switches on, commit at frame start, frozen mid-frame.
    iGRAY_SW = 1'b1; iBINARY_SW = 1'b1; tick(DBI + 4);
    push("t2_pre", 1'b0, 1'b0, DEF_T, 1'b0); pop_check;
    snap = chg_cnt;
    iFVAL = 1'b1;
    push("t2_rise", 1'b1, 1'b1, DEF_T, 1'b1); tick; pop_check;
    push("t2_next", 1'b1, 1'b1, DEF_T, 1'b0); tick; pop_check;
    for (int i = 0; i < 3; i++) begin
      iGRAY_SW = ~iGRAY_SW; iBINARY_SW = ~iBINARY_SW; tick(DBI + 4);
    end
    push("t2_mid", 1'b1, 1'b1, DEF_T, 1'b0); pop_check;
    cmp("t2_chg_cnt", chg_cnt - snap, 1);
    iFVAL = 1'b0; tick(2);
    iFVAL = 1'b1;
    push("t2_off", 1'b0, 1'b0, DEF_T, 1'b1); tick; pop_check;
    iFVAL = 1'b0; tick(2);

    // Test 3: binary alone never enables binary mode; grey alone enables grey only.
    iBINARY_SW = 1'b1; iGRAY_SW = 1'b0; tick(DBI + 4);
    snap = chg_cnt;
    iFVAL = 1'b1;
    push("t3_rise", 1'b0, 1'b0, DEF_T, 1'b0); tick; pop_check;
    tick(3); iFVAL = 1'b0; tick(2);
    cmp("t3_chg_cnt", chg_cnt - snap, 0);
    iBINARY_SW = 1'b0; iGRAY_SW = 1'b1; tick(DBI + 4);
    iFVAL = 1'b1;
    push("t3b_rise", 1'b1, 1'b0, DEF_T, 1'b1); tick; pop_check;
    iFVAL = 1'b0; tick(2);

`ifdef ADAPTIVE_THRESH_EN
    // Test 5a: reset in the middle of a frame aborts accumulation.
    iFVAL = 1'b1; iDVAL = 1'b0; tick;
    iDVAL = 1'b1; iGREY = 12'd4000; tick(20000);
    iRST_N = 1'b0; tick;
    push("t5_rst", 1'b0, 1'b0, DEF_T, 1'b0); pop_check;
    tick(2); iRST_N = 1'b1; tick(50);
    iFVAL = 1'b0; iDVAL = 1'b0; tick(3);
    push("t5_abort", 1'b0, 1'b0, DEF_T, 1'b0); pop_check;

    // Test 5b: short frame leaves the threshold alone.
    iFVAL = 1'b1;
    push("t5_short_rise", 1'b1, 1'b0, DEF_T, 1'b1); tick; pop_check;
    iDVAL = 1'b1; iGREY = 12'd3000; tick(500);
    iDVAL = 1'b0; tick(5);
    iDVAL = 1'b1; tick(500);
    iFVAL = 1'b0; iDVAL = 1'b0; tick(4);
    push("t5_short_end", 1'b1, 1'b0, DEF_T, 1'b0); pop_check;

    // Test 4: full frame; pixels past 65536 and iDVAL outside the frame are ignored.
    iDVAL = 1'b1; iGREY = 12'd4095; tick(5);
    iDVAL = 1'b0; iFVAL = 1'b1; tick;
    iDVAL = 1'b1; iGREY = 12'd1000; tick(65536);
    iGREY = 12'd4095; tick(200);
    push("t4_hold", 1'b1, 1'b0, DEF_T, 1'b0); pop_check;
    iFVAL = 1'b0; iDVAL = 1'b0;
    push("t4_fall", 1'b1, 1'b0, DEF_T, 1'b0); tick; pop_check;
    push("t4_upd", 1'b1, 1'b0, 12'd1000, 1'b0); tick; pop_check;
    push("t4_keep", 1'b1, 1'b0, 12'd1000, 1'b0); tick(5); pop_check;
`else
    // Test 6: fixed threshold regardless of pixel data.
    iFVAL = 1'b1; iDVAL = 1'b0; tick;
    iDVAL = 1'b1; iGREY = 12'd500; tick(33000);
    push("t6_mid", 1'b1, 1'b0, DEF_T, 1'b0); pop_check;
    tick(33000);
    iFVAL = 1'b0; iDVAL = 1'b0; tick(4);
    push("t6_end", 1'b1, 1'b0, DEF_T, 1'b0); pop_check;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
